// File: rtl/spart_pkg.sv
// Shared constants for the SPART bus controller: I/O map, divisor FSM states, status bits.
package spart_pkg;

  localparam int          DATA_W      = 8;
  localparam logic [15:0] DEFAULT_DIV = 16'h028A;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  typedef enum logic [1:0] {
    DIV_UNPROG    = 2'b00,
    DIV_LOW_ONLY  = 2'b01,
    DIV_HIGH_ONLY = 2'b10,
    DIV_READY     = 2'b11
  } div_state_t;

  localparam int ST_RDA      = 0;
  localparam int ST_TBR      = 1;
  localparam int ST_TX_OVF   = 2;
  localparam int ST_OVERRUN  = 3;
  localparam int ST_DB_READY = 5;

endpackage

// File: rtl/spart_div_cfg.sv
// Baud divisor buffers plus programming FSM; db_ready is registered and rises the cycle
// after the second byte of a low/high pair lands. No backpressure: writes always take.
module spart_div_cfg #(
  parameter logic [15:0] DEFAULT_DIV = 16'h028A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_low,
  input  logic       wr_high,
  input  logic [7:0] wdata,
  output logic [7:0] db_low,
  output logic [7:0] db_high,
  output logic       db_ready
);
  import spart_pkg::*;

  div_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DIV_UNPROG;
      db_low  <= DEFAULT_DIV[7:0];
      db_high <= DEFAULT_DIV[15:8];
    end else begin
      state_q <= state_d;
      if (wr_low)  db_low  <= wdata;
      if (wr_high) db_high <= wdata;
    end
  end

  // Rewriting a byte in READY restarts the pair so the generator never sees half an update.
  always_comb begin
    state_d = state_q;
    if (wr_low) begin
      if (state_q == DIV_HIGH_ONLY) state_d = DIV_READY;
      else                          state_d = DIV_LOW_ONLY;
    end else if (wr_high) begin
      if (state_q == DIV_LOW_ONLY)  state_d = DIV_READY;
      else                          state_d = DIV_HIGH_ONLY;
    end
  end

  assign db_ready = (state_q == DIV_READY);

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART processor interface: register decode, one-byte TX hold with valid/ready, one-byte RX
// buffer with sticky errors. Effects land at the access edge; a full TX buffer drops writes.
module spart_bus_ctrl #(
  parameter logic [15:0] DEFAULT_DIV = 16'h028A,
  parameter int          DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iocs,
  input  logic              iorw,
  input  logic [1:0]        ioaddr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [7:0]        db_low,
  output logic [7:0]        db_high,
  output logic              db_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              tbr,
  output logic              rda
);
  import spart_pkg::*;

  logic              wr, rd;
  logic              wr_buf, rd_buf, rd_stat;
  logic              rx_take, ovr_set, tx_ovf_set;
  logic              overrun, tx_ovf;
  logic [DATA_W-1:0] rx_buf;
  logic [DATA_W-1:0] status;

  assign wr      = iocs & ~iorw;
  assign rd      = iocs &  iorw;
  assign wr_buf  = wr & (ioaddr == ADDR_BUF);
  assign rd_buf  = rd & (ioaddr == ADDR_BUF);
  assign rd_stat = rd & (ioaddr == ADDR_STATUS);

  spart_div_cfg #(.DEFAULT_DIV(DEFAULT_DIV)) u_div_cfg (
    .clk      (clk),
    .rst      (rst),
    .wr_low   (wr & (ioaddr == ADDR_DBL)),
    .wr_high  (wr & (ioaddr == ADDR_DBH)),
    .wdata    (data_in[7:0]),
    .db_low   (db_low),
    .db_high  (db_high),
    .db_ready (db_ready)
  );

  // TX: the handshake cycle still counts as full, so a write there is an overflow.
  assign tbr        = ~tx_valid;
  assign tx_ovf_set = wr_buf & tx_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (tx_valid) begin
      if (tx_ready) tx_valid <= 1'b0;
    end else if (wr_buf) begin
      tx_valid <= 1'b1;
      tx_data  <= data_in;
    end
  end

  // RX: a same-cycle buffer read frees the slot for the arriving byte.
  assign rx_take = rx_valid & (~rda | rd_buf);
  assign ovr_set = rx_valid &  rda & ~rd_buf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rda     <= 1'b0;
      rx_buf  <= '0;
      overrun <= 1'b0;
      tx_ovf  <= 1'b0;
    end else begin
      if (rx_take) begin
        rda    <= 1'b1;
        rx_buf <= rx_data;
      end else if (rd_buf) begin
        rda    <= 1'b0;
      end
      overrun <= ovr_set    | (overrun & ~rd_stat);
      tx_ovf  <= tx_ovf_set | (tx_ovf  & ~rd_stat);
    end
  end

  always_comb begin
    status              = '0;
    status[ST_RDA]      = rda;
    status[ST_TBR]      = tbr;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_OVERRUN]  = overrun;
    status[ST_DB_READY] = db_ready;
  end

  always_comb begin
    data_out = '0;
    if (rd) begin
      case (ioaddr)
        ADDR_BUF:    data_out = rx_buf;
        ADDR_STATUS: data_out = status;
        ADDR_DBL:    data_out = db_low;
        default:     data_out = db_high;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_bus_ctrl.sv
// Bench for spart_bus_ctrl: directed vector table, reset corner sequence, randomized run vs model.
module tb_spart_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iocs = 1'b0, iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] data_in = 8'h00;
  logic       tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] data_out, db_low, db_high, tx_data;
  logic       db_ready, tx_valid, tbr, rda;

  spart_bus_ctrl dut (
    .clk(clk), .rst(rst), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .data_in(data_in), .data_out(data_out), .db_low(db_low), .db_high(db_high),
    .db_ready(db_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .tbr(tbr), .rda(rda)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the edge; data_out is sampled mid-cycle.
  task automatic cycle(input logic r, input logic cs, input logic rw, input logic [1:0] a,
                       input logic [7:0] d, input logic txr, input logic rxv,
                       input logic [7:0] rxd, output logic [7:0] dout);
    rst = r; iocs = cs; iorw = rw; ioaddr = a; data_in = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    #1;
    dout = data_out;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       cs, rw;
    logic [1:0] addr;
    logic [7:0] din;
    logic       txr, rxv;
    logic [7:0] rxd;
    logic [7:0] dout;
    logic       tbr, rda, rdy, txv;
    logic [7:0] txd, dbl, dbh;
  } vec_t;

  function automatic vec_t mk(logic cs, logic rw, logic [1:0] addr, logic [7:0] din,
                              logic txr, logic rxv, logic [7:0] rxd, logic [7:0] dout,
                              logic tb, logic rd, logic rdy, logic txv, logic [7:0] txd,
                              logic [7:0] dbl, logic [7:0] dbh);
    vec_t v;
    v.cs = cs; v.rw = rw; v.addr = addr; v.din = din; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
    v.dout = dout; v.tbr = tb; v.rda = rd; v.rdy = rdy; v.txv = txv; v.txd = txd;
    v.dbl = dbl; v.dbh = dbh;
    return v;
  endfunction

  // Reference model: divisor as two "byte written" flags, TX and RX as depth-one queues.
  logic [7:0] m_low, m_high, m_rxbuf;
  bit         m_hl, m_hh, m_ovr, m_ovf;
  logic [7:0] m_txq[$];
  logic [7:0] m_rxq[$];

  task automatic m_reset();
    m_low = 8'h8A; m_high = 8'h02; m_hl = 0; m_hh = 0;
    m_txq.delete(); m_rxq.delete(); m_rxbuf = 8'h00; m_ovr = 0; m_ovf = 0;
  endtask

  function automatic logic [7:0] m_read(logic cs, logic rw, logic [1:0] a);
    if (!(cs && rw)) return 8'h00;
    case (a)
      2'b00:   return m_rxbuf;
      2'b01:   return {2'b00, m_hl && m_hh, 1'b0, m_ovr, m_ovf,
                       m_txq.size() == 0, m_rxq.size() != 0};
      2'b10:   return m_low;
      default: return m_high;
    endcase
  endfunction

  task automatic m_update(logic r, logic cs, logic rw, logic [1:0] a, logic [7:0] d,
                          logic txr, logic rxv, logic [7:0] rxd);
    bit wr, rd, ovf_set, ovr_set;
    int tx_pre;
    if (!r) begin
      m_reset();
      return;
    end
    wr = cs && !rw; rd = cs && rw; ovf_set = 0; ovr_set = 0;
    tx_pre = m_txq.size();
    if (wr && a == 2'b00) begin
      if (tx_pre == 0) m_txq.push_back(d);
      else             ovf_set = 1;
    end
    if (tx_pre > 0 && txr) void'(m_txq.pop_front());
    if (rd && a == 2'b00 && m_rxq.size() > 0) void'(m_rxq.pop_front());
    if (rxv) begin
      if (m_rxq.size() == 0) begin
        m_rxq.push_back(rxd);
        m_rxbuf = rxd;
      end else begin
        ovr_set = 1;
      end
    end
    if (rd && a == 2'b01) begin m_ovr = 0; m_ovf = 0; end
    if (ovr_set) m_ovr = 1;
    if (ovf_set) m_ovf = 1;
    if (wr && a == 2'b10) begin
      if (m_hl && m_hh) m_hh = 0;
      m_hl = 1; m_low = d;
    end
    if (wr && a == 2'b11) begin
      if (m_hl && m_hh) m_hl = 0;
      m_hh = 1; m_high = d;
    end
  endtask

  vec_t       tbl[$];
  logic [7:0] dv;

  initial begin
    //               cs rw addr   din   txr rxv rxd    dout  tbr rda rdy txv txd    dbl    dbh
    tbl.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 8'h02, 1, 0, 0, 0, 8'h00, 8'h8A, 8'h02));
    tbl.push_back(mk(1, 0, 2'b10, 8'h45, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h45, 8'h02));
    tbl.push_back(mk(1, 1, 2'b10, 8'h00, 0, 0, 8'h00, 8'h45, 1, 0, 0, 0, 8'h00, 8'h45, 8'h02));
    tbl.push_back(mk(1, 0, 2'b11, 8'h01, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h45, 8'h01));
    tbl.push_back(mk(1, 1, 2'b11, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 1, 0, 8'h00, 8'h45, 8'h01));
    tbl.push_back(mk(1, 0, 2'b10, 8'h20, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b10, 8'h00, 0, 0, 8'h00, 8'h20, 1, 0, 0, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 0, 2'b11, 8'h01, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 0, 2'b00, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA5, 8'h20, 8'h01));
    tbl.push_back(mk(0, 0, 2'b00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA5, 8'h20, 8'h01));
    tbl.push_back(mk(1, 0, 2'b00, 8'h3C, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA5, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'hA5, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 8'h24, 0, 0, 1, 1, 8'hA5, 8'h20, 8'h01));
    tbl.push_back(mk(0, 0, 2'b00, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 8'h22, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 0, 2'b00, 8'h77, 0, 0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h77, 8'h20, 8'h01));
    tbl.push_back(mk(1, 0, 2'b00, 8'h88, 1, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 8'h26, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(0, 0, 2'b00, 8'h00, 0, 1, 8'h5A, 8'h00, 1, 1, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(0, 0, 2'b00, 8'h00, 0, 1, 8'hC3, 8'h00, 1, 1, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 8'h2B, 1, 1, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b00, 8'h00, 0, 0, 8'h00, 8'h5A, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 8'h22, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(0, 0, 2'b00, 8'h00, 0, 1, 8'h11, 8'h00, 1, 1, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b01, 8'h00, 0, 1, 8'h99, 8'h23, 1, 1, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 8'h2B, 1, 1, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b00, 8'h00, 0, 1, 8'h22, 8'h11, 1, 1, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b01, 8'h00, 0, 0, 8'h00, 8'h23, 1, 1, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b00, 8'h00, 0, 0, 8'h00, 8'h22, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(0, 0, 2'b10, 8'hFF, 0, 0, 8'h00, 8'h00, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));
    tbl.push_back(mk(1, 1, 2'b10, 8'h00, 0, 0, 8'h00, 8'h20, 1, 0, 1, 0, 8'h00, 8'h20, 8'h01));

    // Reset state.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst db_low",   db_low,   8'h8A);
    check("rst db_high",  db_high,  8'h02);
    check("rst db_ready", db_ready, 1'b0);
    check("rst tx_valid", tx_valid, 1'b0);
    check("rst tx_data",  tx_data,  8'h00);
    check("rst tbr",      tbr,      1'b1);
    check("rst rda",      rda,      1'b0);

    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].cs, tbl[i].rw, tbl[i].addr, tbl[i].din, tbl[i].txr,
            tbl[i].rxv, tbl[i].rxd, dv);
      check($sformatf("row%0d data_out", i), dv,       tbl[i].dout);
      check($sformatf("row%0d tbr", i),      tbr,      tbl[i].tbr);
      check($sformatf("row%0d rda", i),      rda,      tbl[i].rda);
      check($sformatf("row%0d db_ready", i), db_ready, tbl[i].rdy);
      check($sformatf("row%0d tx_valid", i), tx_valid, tbl[i].txv);
      check($sformatf("row%0d db_low", i),   db_low,   tbl[i].dbl);
      check($sformatf("row%0d db_high", i),  db_high,  tbl[i].dbh);
      if (tbl[i].txv) check($sformatf("row%0d tx_data", i), tx_data, tbl[i].txd);
    end

    // Mid-TX reset with db_ready=1, colliding with a divisor write and an RX byte.
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 8'hEE, 1'b0, 1'b0, 8'h00, dv);
    check("midrst pre tx_valid", tx_valid, 1'b1);
    check("midrst pre db_ready", db_ready, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 2'b10, 8'h55, 1'b0, 1'b1, 8'h66, dv);
    check("midrst tx_valid", tx_valid, 1'b0);
    check("midrst tbr",      tbr,      1'b1);
    check("midrst db_ready", db_ready, 1'b0);
    check("midrst db_low",   db_low,   8'h8A);
    check("midrst db_high",  db_high,  8'h02);
    check("midrst rda",      rda,      1'b0);
    check("midrst tx_data",  tx_data,  8'h00);
    cycle(1'b1, 1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0, 8'h00, dv);
    check("midrst status", dv, 8'h02);

    // Randomized run against the model.
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 8'h00, dv);
    m_reset();
    for (int i = 0; i < 3000; i++) begin
      logic       r, cs, rw, txr, rxv;
      logic [1:0] a;
      logic [7:0] d, rxd, exp_dout;
      r   = ($urandom_range(0, 99) != 0);
      cs  = ($urandom_range(0, 1) == 1);
      rw  = ($urandom_range(0, 1) == 1);
      a   = 2'($urandom_range(0, 3));
      d   = 8'($urandom);
      txr = ($urandom_range(0, 2) == 0);
      rxv = ($urandom_range(0, 3) == 0);
      rxd = 8'($urandom);
      exp_dout = m_read(cs, rw, a);
      cycle(r, cs, rw, a, d, txr, rxv, rxd, dv);
      m_update(r, cs, rw, a, d, txr, rxv, rxd);
      check($sformatf("rnd%0d data_out", i), dv,       exp_dout);
      check($sformatf("rnd%0d tbr", i),      tbr,      m_txq.size() == 0);
      check($sformatf("rnd%0d tx_valid", i), tx_valid, m_txq.size() != 0);
      check($sformatf("rnd%0d rda", i),      rda,      m_rxq.size() != 0);
      check($sformatf("rnd%0d db_ready", i), db_ready, m_hl && m_hh);
      check($sformatf("rnd%0d db_low", i),   db_low,   m_low);
      check($sformatf("rnd%0d db_high", i),  db_high,  m_high);
      if (m_txq.size() != 0) check($sformatf("rnd%0d tx_data", i), tx_data, m_txq[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
